// File: rtl/onchip_mem_loader.sv
// Boot loader for the on-chip RAM: packs a byte stream into 32-bit words, writes them,
// then reads the region back and compares checksums while holding the CPU in reset.
module onchip_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              mem_clken,
  output logic              cpu_reset_req,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_VERIFY, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_in;
  logic [ADDR_W:0]     widx, ridx;
  logic [1:0]          bcnt;
  logic [DATA_W-1:0]   word_q, wsum, rsum;
  logic                rd_valid;
  logic                done_q, pass_q;
  logic [DATA_W-1:0]   checksum_q;
  logic                accept;

  assign count_in       = (word_count > CNT_MAX) ? CNT_MAX : word_count;
  assign accept         = (state == S_COLLECT) && s_valid;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign mem_writedata  = word_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign checksum       = checksum_q;

  always_comb begin
    s_ready        = (state == S_COLLECT);
    busy           = (state == S_COLLECT) || (state == S_WRITE) ||
                     (state == S_VERIFY)  || (state == S_DRAIN);
    cpu_reset_req  = busy;
    mem_chipselect = (state == S_WRITE) || (state == S_VERIFY);
    mem_write      = (state == S_WRITE);
    mem_address    = '0;
    if (state == S_WRITE)
      mem_address = base_q + widx[ADDR_W-1:0];
    else if (state == S_VERIFY)
      mem_address = base_q + ridx[ADDR_W-1:0];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start)
          state_nx = (word_count == '0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        if (accept && (bcnt == 2'd3))
          state_nx = S_WRITE;
      end
      S_WRITE:  state_nx = ((widx + ONE) == count_q) ? S_VERIFY : S_COLLECT;
      S_VERIFY: state_nx = ((ridx + ONE) == count_q) ? S_DRAIN : S_VERIFY;
      S_DRAIN:  state_nx = S_DONE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      count_q    <= '0;
      widx       <= '0;
      ridx       <= '0;
      bcnt       <= '0;
      word_q     <= '0;
      wsum       <= '0;
      rsum       <= '0;
      rd_valid   <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      checksum_q <= '0;
    end else begin
      // Read data trails its address by one cycle, so the sum lags the address stream.
      rd_valid <= (state == S_VERIFY);
      if (rd_valid)
        rsum <= rsum + mem_readdata;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q     <= base_addr;
            count_q    <= count_in;
            widx       <= '0;
            ridx       <= '0;
            bcnt       <= '0;
            wsum       <= '0;
            rsum       <= '0;
            checksum_q <= '0;
            done_q     <= (word_count == '0);
            pass_q     <= (word_count == '0);
          end
        end
        S_COLLECT: begin
          if (accept) begin
            word_q[{bcnt, 3'b000} +: 8] <= s_data;
            bcnt <= bcnt + 2'd1;
          end
        end
        S_WRITE: begin
          wsum <= wsum + word_q;
          widx <= widx + ONE;
        end
        S_VERIFY: ridx <= ridx + ONE;
        S_DRAIN: begin
          done_q     <= 1'b1;
          pass_q     <= ((rsum + mem_readdata) == wsum);
          checksum_q <= wsum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Self-checking bench for onchip_mem_loader: RAM model, write scoreboard and
// per-scenario tasks comparing done/pass/checksum and read-back addresses.
module tb_onchip_mem_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic [7:0]        s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata = '0;
  logic              cpu_reset_req, busy, done, pass;
  logic [31:0]       checksum;

  onchip_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_clken(mem_clken), .cpu_reset_req(cpu_reset_req), .busy(busy),
    .done(done), .pass(pass), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  wr_t               exp_q[$];
  logic [7:0]        tx_q[$];
  logic [ADDR_W-1:0] rd_log[$];
  int                checks = 0;
  int                errors = 0;
  int                cs_cycles = 0;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic [31:0]       corrupt_mask = 32'h4;

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write)
        ram[mem_address] <= mem_writedata;
      else
        mem_readdata <= ram[mem_address] ^
                        ((corrupt_en && mem_address == corrupt_addr) ? corrupt_mask : 32'h0);
    end
  end

  // Write scoreboard and read-address log, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n && mem_chipselect) begin
      cs_cycles++;
      if (mem_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr %0d data %h", mem_address, mem_writedata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mem_address !== e.addr || mem_writedata !== e.data || mem_byteenable !== 4'hF) begin
            errors++;
            $display("FAIL write addr %0d data %h be %h required addr %0d data %h be f",
                     mem_address, mem_writedata, mem_byteenable, e.addr, e.data);
          end
        end
      end else begin
        rd_log.push_back(mem_address);
      end
    end
  end

  localparam logic [85:0] RST_VEC = {1'b0, 10'd0, 4'hF, 1'b0, 1'b0, 32'd0, 1'b1,
                                     1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

  function automatic logic [85:0] out_vec();
    return {s_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
            mem_clken, cpu_reset_req, busy, done, pass, checksum};
  endfunction

  task automatic push_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) tx_q.push_back(data[8*i +: 8]);
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
    @(negedge clk);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Must be entered on a falling edge; holds each byte until it is accepted.
  task automatic drive_bytes(input int n, input bit rnd);
    int  sent = 0;
    int  guard = 0;
    bit  acc;
    while (sent < n && tx_q.size() > 0 && guard < 4000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = tx_q[0];
      #1;
      acc = s_valid && s_ready;
      @(negedge clk);
      guard++;
      if (acc) begin
        void'(tx_q.pop_front());
        sent++;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL stream_bytes sent %0d required %0d", sent, n);
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout done %b required 1", done);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_outputs got %h required %h", out_vec(), RST_VEC);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int bad = 0;
    int cyc = 0;
    rd_log.delete();
    push_word(10'd0, 32'h12345678);
    @(negedge clk);
    base_addr = '0; word_count = 11'd1; start = 1'b1;
    #1;
    checks++;
    if (cpu_reset_req !== 1'b0) begin
      errors++;
      $display("FAIL cpu_reset_pre got %b required 0", cpu_reset_req);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (cpu_reset_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cpu_reset_start got %b/%b required 1/1", cpu_reset_req, busy);
    end
    drive_bytes(4, 1'b0);
    while (!done && cyc < 100) begin
      if (cpu_reset_req !== 1'b1) bad++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bad != 0 || done !== 1'b1 || cpu_reset_req !== 1'b0) begin
      errors++;
      $display("FAIL single_hold bad %0d done %b cpu_reset_req %b required 0/1/0",
               bad, done, cpu_reset_req);
    end
    checks++;
    if (pass !== 1'b1 || checksum !== 32'h12345678) begin
      errors++;
      $display("FAIL single_result pass %b checksum %h required 1 12345678", pass, checksum);
    end
    checks++;
    if (rd_log.size() != 1 || rd_log[0] !== 10'd0 || ram[0] !== 32'h12345678 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_mem reads %0d ram0 %h pending %0d required 1 12345678 0",
               rd_log.size(), ram[0], exp_q.size());
    end
  endtask

  task automatic test_zero();
    int cs0;
    cs0 = cs_cycles;
    start_load(10'd7, 11'd0);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || checksum !== 32'h0) begin
      errors++;
      $display("FAIL zero_result done %b pass %b checksum %h required 1 1 0", done, pass, checksum);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cs_cycles != cs0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_chipselect cycles %0d busy %b required 0 0", cs_cycles - cs0, busy);
    end
  endtask

  task automatic test_wrap(input bit corrupt);
    logic [ADDR_W-1:0] exp_rd [4];
    exp_rd[0] = 10'd1022; exp_rd[1] = 10'd1023; exp_rd[2] = 10'd0; exp_rd[3] = 10'd1;
    rd_log.delete();
    corrupt_en   = corrupt;
    corrupt_addr = 10'd0;
    for (int i = 0; i < 4; i++) push_word(exp_rd[i], 32'(i + 1));
    start_load(10'd1022, 11'd4);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done_clear done %b required 0", done);
    end
    drive_bytes(16, 1'b0);
    wait_done();
    checks++;
    if (pass !== !corrupt || checksum !== 32'h0000000A) begin
      errors++;
      $display("FAIL wrap_result corrupt %0d pass %b checksum %h required %b 0000000a",
               corrupt, pass, checksum, !corrupt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log.size() != 4 || rd_log[i] !== exp_rd[i]) begin
        errors++;
        $display("FAIL wrap_read_addr idx %0d got %0d required %0d", i,
                 (rd_log.size() > i) ? rd_log[i] : 10'h3FF, exp_rd[i]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_pending writes %0d required 0", exp_q.size());
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [31:0] sum = '0;
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      sum = sum + w;
      push_word(10'(200 + i), w);
    end
    start_load(10'd200, 11'd16);
    drive_bytes(64, 1'b1);
    wait_done();
    checks++;
    if (pass !== 1'b1 || checksum !== sum || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_result pass %b checksum %h pending %0d required 1 %h 0",
               pass, checksum, exp_q.size(), sum);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] a, b;
    push_word(10'd100, 32'hCAFE0001);
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    start_load(10'd100, 11'd4);
    drive_bytes(6, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_vec() !== RST_VEC || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midload_reset got %h pending %0d required %h 0", out_vec(), exp_q.size(), RST_VEC);
    end
    tx_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    a = 32'h0BAD_F00D;
    b = 32'h1357_9BDF;
    push_word(10'd5, a);
    push_word(10'd6, b);
    start_load(10'd5, 11'd2);
    start_load(10'd900, 11'd1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start busy %b done %b required 1 0", busy, done);
    end
    drive_bytes(8, 1'b0);
    wait_done();
    checks++;
    if (pass !== 1'b1 || checksum !== (a + b) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reload_result pass %b checksum %h pending %0d required 1 %h 0",
               pass, checksum, exp_q.size(), a + b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_wrap(1'b0);
    test_wrap(1'b1);
    test_random_stream();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/onchip_mem_loader.md
Name: onchip_mem_loader

Overview:
- Upstream boot-loader stage for the Nios on-chip RAM (1024 x 32, single-port, byte-enabled, 1-cycle read latency).
- Consumes a byte stream (e.g. UART RX), packs bytes little-endian into 32-bit words and writes them through the RAM's Avalon slave port, accumulating a checksum.
- Reads the region back, re-sums it and reports pass/fail.
- Holds the CPU in reset for the whole operation.

Parameters:
- ADDR_W, 10, RAM word-address width (depth = 2^ADDR_W).
- DATA_W, 32, RAM data width; fixed at 32, 4 bytes per word.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- base_addr  in  ADDR_W  first word address; latched on start.
- word_count  in  ADDR_W+1  words to load (0..2^ADDR_W); latched on start.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts byte this cycle.
- mem_address  out  ADDR_W  RAM word address.
- mem_byteenable  out  4  always 4'hF.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  packed word.
- mem_readdata  in  32  RAM read data, valid 1 cycle after address.
- mem_clken  out  1  constant 1.
- cpu_reset_req  out  1  high while busy.
- busy  out  1  not IDLE/DONE.
- done  out  1  level; set on completion, cleared by next accepted start.
- pass  out  1  valid when done=1.
- checksum  out  32  write-pass sum, valid when done=1.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0 except mem_byteenable=4'hF and mem_clken=1. Counters and sums cleared. Reset mid-load abandons the operation; RAM contents are undefined.
- States: IDLE, COLLECT, WRITE, VERIFY, DRAIN, DONE.
- IDLE/DONE + start=1:
  - Latch base_addr and word_count.
  - Clear the byte counter, word counter, wsum and rsum.
  - Clear done and pass.
  - If word_count=0: go to DONE with pass=1, checksum=0. Otherwise go to COLLECT.
- COLLECT: s_ready=1.
  - Byte accepted when s_valid&s_ready.
  - Byte i (i=0..3) goes to bits [8i+7:8i].
  - On the 4th byte, go to WRITE next cycle.
- WRITE: exactly one cycle.
  - mem_chipselect=mem_write=1; mem_address=(base+widx) mod 2^ADDR_W; s_ready=0.
  - wsum += word (mod 2^32); widx++.
  - If widx reaches word_count, go to VERIFY; else go to COLLECT.
  - Bytes presented during WRITE stall (not lost).
  - Peak throughput: one word per 5 cycles.
- VERIFY: chipselect=1, write=0, s_ready=0.
  - Issue one read address per cycle: ridx 0..word_count-1, same wrap rule.
  - Each cycle after an address is issued, rsum += mem_readdata. This is pipelined, so the sum add and the next address overlap.
  - After the last address, go to DRAIN.
- DRAIN: one cycle; add the final readdata, chipselect=0.
  - Then DONE: pass=(rsum==wsum), checksum=wsum, done=1.
- DONE: holds outputs. cpu_reset_req=0. start restarts the operation.
- busy=cpu_reset_req=1 in COLLECT, WRITE, VERIFY, DRAIN.
- mem_chipselect/mem_write are 0 outside WRITE/VERIFY.
- start while busy: ignored.
- Address wrap: base+count > 2^ADDR_W wraps to 0 (e.g. base 1022, count 4 → 1022, 1023, 0, 1).
- word_count > 2^ADDR_W: clamped to 2^ADDR_W.
- s_valid held without s_ready: the byte is not consumed; no bytes are dropped.

Test Plan:
- Reset, start base=0, count=1, bytes 78 56 34 12 → one write at addr 0 of 0x12345678, byteenable F. Verify read at addr 0; done=1, pass=1, checksum=0x12345678; cpu_reset_req high from the cycle after start until DONE.
- count=0 start → done=1, pass=1, checksum=0 the next cycle; no mem_chipselect ever asserted.
- base=1022, count=4, words 1,2,3,4 → writes to 1022, 1023, 0, 1; checksum=0x0000000A; pass=1.
- Same as scenario 3, but the RAM model corrupts the word at addr 0 on read (0x3 → 0x7) → done=1, pass=0, checksum=0x0000000A.
- s_valid toggled randomly, including bytes presented during WRITE cycles; count=16 → all 64 bytes land in order; no byte dropped or duplicated.
- Assert reset_n low mid-COLLECT, then start again → all outputs at reset values immediately; the new load completes with pass=1. A start pulse while busy has no effect.
